// File: rtl/pe_chain_feeder_pkg.sv
// Shared types and constants for the PE chain feeder: FSM state encoding,
// default operand width and the zero operand driven on idle lanes.
package pe_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      FLUSH,
      DONE
   } feed_state_e;

   localparam int PE_DATA_W = 8;
   localparam logic [PE_DATA_W-1:0] ZERO_OPND = '0;

   // Counter must hold both the tap count and the largest frame length.
   function automatic int cnt_width(input int n_taps, input int len_w);
      int a;
      a = $clog2(n_taps + 1);
      return (a > len_w) ? a : len_w;
   endfunction

endpackage

// File: rtl/pe_chain_feeder_if.sv
// Handshake and PE-facing bus of the feeder; master is the host/source side,
// slave is the feeder itself.
interface pe_chain_feeder_if #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8
);
   logic              start;
   logic [LEN_W-1:0]  frame_len;
   logic              w_valid;
   logic [DATA_W-1:0] w_data;
   logic              w_ready;
   logic              x_valid;
   logic [DATA_W-1:0] x_data;
   logic              x_ready;
   logic [DATA_W-1:0] pe_a;
   logic              pe_a_vld;
   logic [DATA_W-1:0] pe_b;
   logic              pe_b_en;
   logic [DATA_W-1:0] pe_psum;
   logic              busy;
   logic              done;

   modport master (
      output start, frame_len, w_valid, w_data, x_valid, x_data,
      input  w_ready, x_ready, pe_a, pe_a_vld, pe_b, pe_b_en, pe_psum, busy, done
   );

   modport slave (
      input  start, frame_len, w_valid, w_data, x_valid, x_data,
      output w_ready, x_ready, pe_a, pe_a_vld, pe_b, pe_b_en, pe_psum, busy, done
   );
endinterface

// File: rtl/pe_chain_feeder_cnt.sv
// Up-counter with synchronous clear and a terminal-count flag that is high
// when the next increment reaches tc_val_i.
module pe_feed_cnt #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          inc_i,
   input  logic [CW-1:0] tc_val_i,
   output logic          tc_o
);
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)      cnt_d = '0;
      else if (inc_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Compare one bit wider so a full-scale terminal value never wraps.
   assign tc_o = ({1'b0, cnt_q} + {{CW{1'b0}}, 1'b1}) == {1'b0, tc_val_i};

endmodule

// File: rtl/pe_chain_feeder.sv
// Sequencer feeding a 1-D MAC PE chain: loads N_TAPS weights via b_en, streams
// frame_len activations, flushes N_TAPS zeros, then pulses done.
module pe_chain_feeder
   import pe_pkg::*;
#(
   parameter int N_TAPS = 3,
   parameter int DATA_W = PE_DATA_W,
   parameter int LEN_W  = 8
) (
   input logic               clk,
   input logic               rst,
   pe_chain_feeder_if.slave  bus
);
   localparam int CW = cnt_width(N_TAPS, LEN_W);

   feed_state_e       state_q;
   logic [LEN_W-1:0]  len_q;
   logic [DATA_W-1:0] pe_a_q, pe_b_q;
   logic              pe_a_vld_q, pe_b_en_q;

   logic              w_rdy, x_rdy, w_hs, x_hs;
   logic              cnt_clr, cnt_inc, cnt_tc;
   logic [CW-1:0]     tc_val;

   assign w_rdy = (state_q == LOAD_W);
   assign x_rdy = (state_q == STREAM);
   assign w_hs  = bus.w_valid & w_rdy;
   assign x_hs  = bus.x_valid & x_rdy;

   // One counter serves all three phases; it idles at zero so start needs no extra clear.
   assign cnt_clr = (state_q == IDLE) | ((w_hs | x_hs | (state_q == FLUSH)) & cnt_tc);
   assign cnt_inc = w_hs | x_hs | (state_q == FLUSH);
   assign tc_val  = (state_q == STREAM) ? CW'(len_q) : CW'(N_TAPS);

   pe_feed_cnt #(.CW(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (cnt_clr),
      .inc_i    (cnt_inc),
      .tc_val_i (tc_val),
      .tc_o     (cnt_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         pe_a_q     <= '0;
         pe_a_vld_q <= 1'b0;
         pe_b_q     <= '0;
         pe_b_en_q  <= 1'b0;
      end else begin
         // Default: bubble on the a-path, weights frozen in the chain.
         pe_a_q     <= DATA_W'(ZERO_OPND);
         pe_a_vld_q <= 1'b0;
         pe_b_en_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  len_q   <= bus.frame_len;
                  state_q <= (bus.frame_len == '0) ? DONE : LOAD_W;
               end
            end
            LOAD_W: begin
               if (w_hs) begin
                  pe_b_q    <= bus.w_data;
                  pe_b_en_q <= 1'b1;
                  if (cnt_tc) state_q <= STREAM;
               end
            end
            STREAM: begin
               if (x_hs) begin
                  pe_a_q     <= bus.x_data;
                  pe_a_vld_q <= 1'b1;
                  if (cnt_tc) state_q <= FLUSH;
               end
            end
            FLUSH: begin
               if (cnt_tc) state_q <= DONE;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.w_ready  = w_rdy;
   assign bus.x_ready  = x_rdy;
   assign bus.pe_a     = pe_a_q;
   assign bus.pe_a_vld = pe_a_vld_q;
   assign bus.pe_b     = pe_b_q;
   assign bus.pe_b_en  = pe_b_en_q;
   assign bus.pe_psum  = DATA_W'(ZERO_OPND);
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_pe_chain_feeder.sv
// Randomized bench for pe_chain_feeder: each frame is planned as a schedule of
// source gaps, and the expected per-cycle outputs are derived from that plan.
module tb_pe_chain_feeder;
   localparam int N    = 3;
   localparam int DW   = 8;
   localparam int LW   = 8;
   localparam int MAXC = 2048;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pe_chain_feeder_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

   pe_chain_feeder #(.N_TAPS(N), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW-1:0] last_b;
   logic [DW-1:0] wv [N];
   int            gw [N];
   logic [DW-1:0] xv [256];
   int            gx [256];
   int            w_at [MAXC];
   int            x_at [MAXC];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   function automatic logic [31:0] obs();
      return {2'b00, bus.w_ready, bus.x_ready, bus.busy, bus.done, bus.pe_b_en, bus.pe_b,
              bus.pe_a_vld, bus.pe_a, bus.pe_psum};
   endfunction

   task automatic plan(input int len, input int gmax);
      for (int i = 0; i < N; i++) begin
         wv[i] = DW'($urandom);
         gw[i] = $urandom_range(0, gmax);
      end
      for (int j = 0; j < len; j++) begin
         xv[j] = DW'($urandom);
         gx[j] = $urandom_range(0, gmax);
      end
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1 idle.
   task automatic run_frame(input int len, input bit noise, input int abort_at);
      int c, lw_end, ls_end, d, n_ben, n_done, n_wr, done_k;
      logic [31:0] ev;
      for (int k = 0; k < MAXC; k++) begin
         w_at[k] = -1;
         x_at[k] = -1;
      end
      if (len == 0) begin
         lw_end = 0; ls_end = 0; d = 1;
      end else begin
         c = 1;
         for (int i = 0; i < N; i++) begin
            c += gw[i]; w_at[c] = i; c++;
         end
         lw_end = c - 1;
         for (int j = 0; j < len; j++) begin
            c += gx[j]; x_at[c] = j; c++;
         end
         ls_end = c - 1;
         d = ls_end + N + 1;
      end
      n_ben = 0; n_done = 0; n_wr = 0; done_k = -1;
      for (int k = 0; k <= d + 1; k++) begin
         logic wr_e, xr_e, ben_e, avld_e;
         logic [DW-1:0] a_e;
         wr_e = (k >= 1) && (k <= lw_end);
         xr_e = (k > lw_end) && (k <= ls_end);
         bus.start     = (k == 0) ? 1'b1 : ((noise && k <= d) ? 1'($urandom_range(0, 1)) : 1'b0);
         bus.frame_len = (k == 0) ? LW'(len) : LW'($urandom);
         if (w_at[k] >= 0) begin
            bus.w_valid = 1'b1; bus.w_data = wv[w_at[k]];
         end else begin
            bus.w_valid = (!wr_e && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.w_data  = DW'($urandom);
         end
         if (x_at[k] >= 0) begin
            bus.x_valid = 1'b1; bus.x_data = xv[x_at[k]];
         end else begin
            bus.x_valid = (!xr_e && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.x_data  = DW'($urandom);
         end
         ben_e  = (k >= 1) && (w_at[k-1] >= 0);
         if (ben_e) last_b = wv[w_at[k-1]];
         avld_e = (k >= 1) && (x_at[k-1] >= 0);
         a_e    = avld_e ? xv[x_at[k-1]] : '0;
         ev = {2'b00, wr_e, xr_e, (k >= 1 && k <= d), (k == d), ben_e, last_b, avld_e, a_e, 8'h00};
         @(negedge clk);
         chk($sformatf("cyc%0d_len%0d", k, len), 64'(obs()), 64'(ev));
         if (bus.pe_b_en) n_ben++;
         if (bus.w_ready) n_wr++;
         if (bus.done) begin n_done++; done_k = k; end
         if (k == abort_at) begin
            #1 rst = 1'b1;
            #1 chk("rst_async_outs", 64'(obs()), 64'h0);
            last_b = '0;
            bus.start = 1'b0; bus.w_valid = 1'b0; bus.x_valid = 1'b0;
            @(posedge clk); #1 rst = 1'b0;
            for (int r = 0; r < 4; r++) begin
               @(negedge clk);
               chk($sformatf("post_rst_idle%0d", r), 64'(obs()), 64'h0);
            end
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      chk($sformatf("b_en_pulses_len%0d", len), 64'(n_ben), 64'((len == 0) ? 0 : N));
      chk($sformatf("done_pulses_len%0d", len), 64'(n_done), 64'd1);
      chk($sformatf("done_cycle_len%0d", len), 64'(done_k), 64'(d));
      chk($sformatf("w_ready_cycles_len%0d", len), 64'(n_wr), 64'(lw_end));
   endtask

   initial begin
      bus.start = 1'b0; bus.frame_len = '0;
      bus.w_valid = 1'b0; bus.w_data = '0;
      bus.x_valid = 1'b0; bus.x_data = '0;
      last_b = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("reset_outs", 64'(obs()), 64'h0);
      rst = 1'b0;

      // Basic frame: weights 5,6,7 then samples 1..4, sources always valid.
      for (int i = 0; i < N; i++) begin wv[i] = DW'(5 + i); gw[i] = 0; end
      for (int j = 0; j < 4; j++) begin xv[j] = DW'(1 + j); gx[j] = 0; end
      run_frame(4, 1'b0, -1);

      // Weight stall of two cycles before the last weight.
      gw[2] = 2;
      run_frame(4, 1'b0, -1);

      // Activation bubbles: valid pattern 1,0,1,0,...
      gw[2] = 0;
      for (int j = 1; j < 4; j++) gx[j] = 1;
      run_frame(4, 1'b0, -1);

      // Empty frame with stray valids on both sources.
      run_frame(0, 1'b1, -1);

      // Random starts while busy must be ignored.
      plan(6, 2);
      run_frame(6, 1'b1, -1);

      for (int f = 0; f < 12; f++) begin
         int len;
         len = $urandom_range(1, 24);
         plan(len, 2);
         run_frame(len, 1'b1, -1);
      end

      // Full-scale frame length.
      plan(255, 0);
      run_frame(255, 1'b1, -1);

      // Reset after 2 of 5 samples reached the a-path, then a clean len=1 frame.
      plan(5, 0);
      run_frame(5, 1'b0, 6);
      plan(1, 1);
      run_frame(1, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
